// File: rtl/chess_pkg.sv
// Shared definitions for the chess clock: FSM state encoding and the
// default widths of the minute/second counts coming out of countDown.
package chess_pkg;

  // Default widths, shared with the countDown blocks
  localparam int DEF_MIN_W = 6;
  localparam int DEF_SEG_W = 6;

  // Turn sequencer states; the numeric values are shown on the display
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN_A = 3'd2,
    RUN_B = 3'd3,
    PAUSE = 3'd4,
    FLAG  = 3'd5
  } turn_state_t;

endpackage

// File: rtl/chess_turn_ctrl_buzz_timer.sv
// Tick-counted one-shot: once started, active stays high for TICKS tick
// pulses and then drops. A tick arriving in the start cycle is not counted.
module buzz_timer #(
  parameter int TICKS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic start,
  input  logic tick,
  output logic active
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] cnt;

  // Count ticks while active; clear wins over start, start re-arms the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (clear) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
    end else if (active && tick) begin
      if (cnt == LAST) begin
        active <= 1'b0;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/chess_turn_ctrl.sv
// Turn sequencer for the chess clock. Sits between the debounced button
// pulses and the two countDown blocks: routes setup minute increments,
// gates the 1 Hz decrement onto the player to move, swaps turns on move
// presses, counts moves and raises the flag/buzzer when a clock runs out.
module chess_turn_ctrl
  import chess_pkg::*;
#(
  parameter int MIN_W      = DEF_MIN_W,
  parameter int SEG_W      = DEF_SEG_W,
  parameter int MAX_MIN    = 59,
  parameter int MOVE_W     = 8,
  parameter int BUZZ_TICKS = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_1hz,
  input  logic              btn_set,
  input  logic              btn_min_a,
  input  logic              btn_min_b,
  input  logic              btn_start,
  input  logic              btn_a,
  input  logic              btn_b,
  input  logic              btn_pause,
  input  logic              btn_clear,
  input  logic [MIN_W-1:0]  min_a,
  input  logic [SEG_W-1:0]  seg_a,
  input  logic [MIN_W-1:0]  min_b,
  input  logic [SEG_W-1:0]  seg_b,
  output logic              cnt_reset,
  output logic              cnt_set,
  output logic              cnt_min_a,
  output logic              cnt_min_b,
  output logic              cnt_en_a,
  output logic              cnt_en_b,
  output logic              turn,
  output logic              flag_a,
  output logic              flag_b,
  output logic              buzzer,
  output logic [MOVE_W-1:0] moves,
  output logic [2:0]        state
);

  localparam logic [MIN_W-1:0] MAX_MIN_V = MIN_W'(MAX_MIN);

  turn_state_t state_q;
  logic        zero_a;
  logic        zero_b;
  logic        fall_a;
  logic        fall_b;
  logic        buzz_start;

  assign zero_a = (min_a == '0) && (seg_a == '0);
  assign zero_b = (min_b == '0) && (seg_b == '0);

  // A flag falls only for the player whose clock is actually running
  assign fall_a = (state_q == RUN_A) && zero_a;
  assign fall_b = (state_q == RUN_B) && zero_b;

  // Buzzer arms on the same edge that enters FLAG; clear overrides it
  assign buzz_start = !btn_clear && (fall_a || fall_b);

  // Decrement enables are combinational so a tick in the same cycle as a
  // move press still charges the player who was moving
  assign cnt_en_a = tick_1hz && (state_q == RUN_A) && !zero_a;
  assign cnt_en_b = tick_1hz && (state_q == RUN_B) && !zero_b;

  assign state = state_q;

  // Main sequencer: clear > flag fall > pause > move press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_reset <= 1'b1;
      cnt_set   <= 1'b0;
      cnt_min_a <= 1'b0;
      cnt_min_b <= 1'b0;
      turn      <= 1'b0;
      flag_a    <= 1'b0;
      flag_b    <= 1'b0;
      moves     <= '0;
    end else begin
      cnt_reset <= 1'b0;
      cnt_min_a <= 1'b0;
      cnt_min_b <= 1'b0;
      if (btn_clear) begin
        state_q   <= IDLE;
        cnt_reset <= 1'b1;
        cnt_set   <= 1'b0;
        turn      <= 1'b0;
        flag_a    <= 1'b0;
        flag_b    <= 1'b0;
        moves     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (btn_set) begin
              state_q <= SETUP;
              cnt_set <= 1'b1;
            end else if (btn_start && !zero_a && !zero_b) begin
              state_q <= RUN_A;
              turn    <= 1'b0;
            end
          end
          SETUP: begin
            if (btn_set) begin
              state_q <= IDLE;
              cnt_set <= 1'b0;
            end else begin
              cnt_min_a <= btn_min_a && (min_a != MAX_MIN_V);
              cnt_min_b <= btn_min_b && (min_b != MAX_MIN_V);
            end
          end
          RUN_A: begin
            if (fall_a) begin
              state_q <= FLAG;
              flag_a  <= 1'b1;
            end else if (btn_pause) begin
              state_q <= PAUSE;
            end else if (btn_a) begin
              state_q <= RUN_B;
              turn    <= 1'b1;
              if (moves != '1) moves <= moves + MOVE_W'(1);
            end
          end
          RUN_B: begin
            if (fall_b) begin
              state_q <= FLAG;
              flag_b  <= 1'b1;
            end else if (btn_pause) begin
              state_q <= PAUSE;
            end else if (btn_b) begin
              state_q <= RUN_A;
              turn    <= 1'b0;
              if (moves != '1) moves <= moves + MOVE_W'(1);
            end
          end
          PAUSE: begin
            if (btn_pause) state_q <= turn ? RUN_B : RUN_A;
          end
          FLAG: begin
            state_q <= FLAG;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  buzz_timer #(
    .TICKS(BUZZ_TICKS)
  ) u_buzz (
    .clk    (clk),
    .reset  (reset),
    .clear  (btn_clear),
    .start  (buzz_start),
    .tick   (tick_1hz),
    .active (buzzer)
  );

endmodule
